ram_init_ctrl: RTL and testbench

Downstream consumer of the RAM initialisation sequencer. It takes the sequencer's enable/address stream and writes a fixed fill pattern into an internal single-port synchronous RAM. It then opens that RAM to a user port with a valid/ready request handshake and a fixed-latency read response. It is the only owner of the RAM; no other block drives its port.

---
 rtl/ram_init_pkg.sv | 19 +
 rtl/ram_init_ctrl_if.sv | 31 +++
 rtl/ram_sp_sync.sv | 33 +++
 rtl/ram_init_ctrl.sv | 104 ++++++++++
 tb/tb_ram_init_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_init_pkg.sv
// ram_init_pkg
// Shared constants for the RAM initialisation path: FSM state encoding of
// ram_init_ctrl and the default address/data widths agreed with the
// upstream initialisation sequencer.
package ram_init_pkg;

  // Defaults shared with the upstream sequencer; its address width must
  // match ADDR_W of ram_init_ctrl.
  localparam int PKG_ADDR_W = 3;
  localparam int PKG_DATA_W = 8;

  typedef logic [1:0] state_t;

  // Encoded as plain constants so legacy code can compare raw bit patterns.
  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

endpackage

// File: rtl/ram_init_ctrl_if.sv
// ram_init_ctrl_if
// User-side request/response bundle of ram_init_ctrl.
//   req_valid / req_ready : request handshake
//   req_we, req_addr, req_wdata : request payload
//   rsp_valid / rsp_rdata : read response, no back-pressure
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. The master keeps req_valid and the payload stable
// until that edge. rsp_valid is a single-cycle pulse that the master must
// always accept; rsp_rdata holds its last value between pulses.
interface ram_init_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_sp_sync.sv
// ram_sp_sync
// Single-port synchronous RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
// One access per cycle; the read is registered and returns the contents
// before a same-cycle write. Storage has no reset.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data of addr_i from the previous edge
module ram_sp_sync #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl
// Consumes the init sequencer's enable/address stream, fills the internal
// RAM with FILL, then opens the RAM to a user request port.
//   sys_clk     : clock, rising edge
//   sys_rst     : asynchronous active-high reset
//   intial_en   : fill strobe, one FILL write per cycle while high
//   intial_addr : fill address, qualified by intial_en
//   init_done   : registered, high while the user port is open (READY)
//   usr         : user request/response bundle (slave side)
//   dbg_state   : current FSM state for observation
module ram_init_ctrl
  import ram_init_pkg::*;
#(
  parameter int              ADDR_W = PKG_ADDR_W,
  parameter int              DATA_W = PKG_DATA_W,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              intial_en,
  input  logic [ADDR_W-1:0] intial_addr,
  output logic              init_done,
  ram_init_ctrl_if.slave    usr,
  output logic [1:0]        dbg_state
);

  state_t            state_q, state_d;
  logic              init_done_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_hold_q;

  logic              accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // ---------------------------------------------------------------- FSM
  // Any state moves to INIT when intial_en is high, so intial_en alone
  // marks a fill cycle (including the WAIT exit and the READY re-init).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:  if (intial_en)  state_d = ST_INIT;
      ST_INIT:  if (!intial_en) state_d = ST_READY;
      ST_READY: if (intial_en)  state_d = ST_INIT;
      default:  state_d = ST_WAIT;
    endcase
  end

  // The fill strobe pre-empts user traffic in the same cycle.
  assign usr.req_ready = (state_q == ST_READY) && !intial_en;
  assign accept        = usr.req_valid && usr.req_ready;

  // ----------------------------------------------------------- port mux
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = usr.req_addr;
    ram_wdata = usr.req_wdata;
    if (intial_en) begin
      ram_we    = 1'b1;
      ram_addr  = intial_addr;
      ram_wdata = FILL;
    end else begin
      ram_we    = accept && usr.req_we;
    end
  end

  ram_sp_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // ------------------------------------------------------------ registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_WAIT;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == ST_READY);
      rsp_valid_q <= accept && !usr.req_we;
      // The RAM reads every cycle, so its output is captured here to keep
      // rsp_rdata steady after the response pulse.
      if (rsp_valid_q) begin
        rsp_hold_q <= ram_rdata;
      end
    end
  end

  assign usr.rsp_valid = rsp_valid_q;
  assign usr.rsp_rdata = rsp_valid_q ? ram_rdata : rsp_hold_q;
  assign init_done     = init_done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_init_ctrl.sv
// tb_ram_init_ctrl
// Scoreboard bench for ram_init_ctrl with ADDR_W=3, DATA_W=8, FILL=8'hA5.
module tb_ram_init_ctrl;
  import ram_init_pkg::*;

  localparam int              ADDR_W = 3;
  localparam int              DATA_W = 8;
  localparam logic [DATA_W-1:0] FILL = 8'hA5;

  // ------------------------------------------------ clock / reset block
  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              intial_en = 1'b0;
  logic [ADDR_W-1:0] intial_addr = '0;
  logic              init_done;
  logic [1:0]        dbg_state;

  always #5 sys_clk = ~sys_clk;

  ram_init_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) usr ();

  ram_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .FILL   (FILL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .intial_en   (intial_en),
    .intial_addr (intial_addr),
    .init_done   (init_done),
    .usr         (usr.master),
    .dbg_state   (dbg_state)
  );

  // ------------------------------------------------------- scoreboard
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] model [1 << ADDR_W];
  logic [DATA_W-1:0] mon_exp;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (usr.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_rdata", {24'd0, usr.rsp_rdata}, {24'd0, mon_exp});
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic init_fill(input logic [ADDR_W-1:0] start, input int n, input logic was_ready);
    for (int i = 0; i < n; i++) begin
      intial_en   = 1'b1;
      intial_addr = start + ADDR_W'(i);
      @(negedge sys_clk);
      check("init_req_ready", {31'd0, usr.req_ready}, 32'd0);
      if (i == 0) begin
        check("init_done_first", {31'd0, init_done}, {31'd0, was_ready});
        check("state_first", {30'd0, dbg_state}, was_ready ? 32'(ST_READY) : 32'(ST_WAIT));
      end else begin
        check("init_done_mid", {31'd0, init_done}, 32'd0);
        check("state_init", {30'd0, dbg_state}, 32'(ST_INIT));
      end
      model[intial_addr] = FILL;
      step();
    end
    intial_en = 1'b0;
    @(negedge sys_clk);
    check("init_done_fall_cycle", {31'd0, init_done}, 32'd0);
    check("init_req_ready_last", {31'd0, usr.req_ready}, 32'd0);
    step();
  endtask

  // Drives one request and holds it until accepted (bounded).
  task automatic do_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int waited;
    waited        = 0;
    usr.req_valid = 1'b1;
    usr.req_we    = we;
    usr.req_addr  = a;
    usr.req_wdata = d;
    @(negedge sys_clk);
    while (usr.req_ready !== 1'b1 && waited < 50) begin
      step();
      @(negedge sys_clk);
      waited++;
    end
    check("req_ready", {31'd0, usr.req_ready}, 32'd1);
    if (usr.req_ready === 1'b1) begin
      if (we) model[a] = d;
      else    exp_q.push_back(model[a]);
    end
    step();
  endtask

  task automatic idle(input int n);
    usr.req_valid = 1'b0;
    repeat (n) step();
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    usr.req_valid = 1'b1;   // request held from reset: stall case
    usr.req_we    = 1'b0;
    usr.req_addr  = 3'd3;
    usr.req_wdata = '0;

    #2;
    check("rst_state", {30'd0, dbg_state}, 32'(ST_WAIT));
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rsp_valid", {31'd0, usr.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", {24'd0, usr.rsp_rdata}, 32'd0);
    check("rst_req_ready", {31'd0, usr.req_ready}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // WAIT holds off the request.
    repeat (2) begin
      @(negedge sys_clk);
      check("wait_state", {30'd0, dbg_state}, 32'(ST_WAIT));
      check("wait_req_ready", {31'd0, usr.req_ready}, 32'd0);
      step();
    end

    // Full fill 0..7, then the held read is taken on the first READY cycle.
    init_fill(3'd0, 8, 1'b0);
    @(negedge sys_clk);
    check("init_done_rise", {31'd0, init_done}, 32'd1);
    check("stall_accept", {31'd0, usr.req_ready}, 32'd1);
    if (usr.req_ready === 1'b1) exp_q.push_back(model[3]);
    step();
    idle(2);

    // Every location reads back FILL.
    for (int i = 0; i < 8; i++) do_req(1'b0, ADDR_W'(i), '0);
    idle(2);

    // Write then immediate read of the same address.
    do_req(1'b1, 3'd5, 8'h3C);
    do_req(1'b0, 3'd5, '0);
    idle(2);

    // Distinct data, then three back-to-back reads.
    do_req(1'b1, 3'd0, 8'h11);
    do_req(1'b1, 3'd1, 8'h22);
    do_req(1'b1, 3'd2, 8'h33);
    do_req(1'b0, 3'd0, '0);
    do_req(1'b0, 3'd1, '0);
    do_req(1'b0, 3'd2, '0);
    idle(3);
    @(negedge sys_clk);
    check("rsp_hold_data", {24'd0, usr.rsp_rdata}, 32'h33);
    check("rsp_hold_valid", {31'd0, usr.rsp_valid}, 32'd0);
    step();

    // Re-init collides with a read of addr 5 (holding 3C).
    usr.req_valid = 1'b1;
    usr.req_we    = 1'b0;
    usr.req_addr  = 3'd5;
    intial_en     = 1'b1;
    intial_addr   = 3'd5;
    @(negedge sys_clk);
    check("coll_req_ready", {31'd0, usr.req_ready}, 32'd0);
    check("coll_init_done", {31'd0, init_done}, 32'd1);
    model[5] = FILL;
    step();
    intial_en = 1'b0;
    @(negedge sys_clk);
    check("coll_done_fell", {31'd0, init_done}, 32'd0);
    check("coll_state", {30'd0, dbg_state}, 32'(ST_INIT));
    check("coll_req_ready_init", {31'd0, usr.req_ready}, 32'd0);
    step();
    @(negedge sys_clk);
    check("coll_done_rise", {31'd0, init_done}, 32'd1);
    check("coll_accept", {31'd0, usr.req_ready}, 32'd1);
    if (usr.req_ready === 1'b1) exp_q.push_back(model[5]);
    step();
    idle(2);

    do_req(1'b1, 3'd6, 8'h66);
    idle(2);

    // Reset lands before the response edge: the read is lost.
    usr.req_valid = 1'b1;
    usr.req_we    = 1'b0;
    usr.req_addr  = 3'd1;
    @(negedge sys_clk);
    check("mid_rst_accept", {31'd0, usr.req_ready}, 32'd1);
    #1 sys_rst = 1'b1;
    usr.req_valid = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      check("mid_rst_rsp_valid", {31'd0, usr.rsp_valid}, 32'd0);
      check("mid_rst_rsp_rdata", {24'd0, usr.rsp_rdata}, 32'd0);
      check("mid_rst_state", {30'd0, dbg_state}, 32'(ST_WAIT));
      check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    end
    step();
    sys_rst = 1'b0;
    step();

    // Partial re-fill; untouched words keep their pre-reset contents.
    init_fill(3'd2, 3, 1'b0);
    @(negedge sys_clk);
    check("refill_done", {31'd0, init_done}, 32'd1);
    step();
    do_req(1'b0, 3'd6, '0);
    do_req(1'b0, 3'd0, '0);
    do_req(1'b0, 3'd2, '0);
    idle(3);

    check("rsp_outstanding", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
